// File: rtl/token_burst_pacer.sv
// Burst pacer: accepts (length, gap) requests and emits credit-limited token pulses.
// Optional macro TOKEN_PACER_ABORT_EN adds an abort input that cancels the running burst.
module token_burst_pacer #(
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4,
  parameter int MAX_OUT = 100,
  localparam int OUT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_len,
  input  logic [GAP_W-1:0] req_gap,
  input  logic             ret,
`ifdef TOKEN_PACER_ABORT_EN
  input  logic             abort,
`endif
  output logic             tok,
  output logic             busy,
  output logic [OUT_W-1:0] outstanding,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_OUT);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_remaining, w_remaining_nxt;
  logic [GAP_W-1:0]   r_gap_ld, w_gap_ld_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [OUT_W-1:0]   r_outstanding;
  logic               r_err;
  logic               w_abort;
  logic               w_fire;
  logic               w_tok;

`ifdef TOKEN_PACER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Handshake: a request transfers on any edge where req_valid && req_ready.
  // req_ready depends only on state and rst, never on req_valid.
  assign req_ready   = (r_state == IDLE) && !rst;
  assign w_fire      = req_valid && req_ready;
  assign w_tok       = (r_state == EMIT) && (r_outstanding < MAX_V) && !rst && !w_abort;
  assign tok         = w_tok;
  assign busy        = (r_state != IDLE);
  assign outstanding = r_outstanding;
  assign err         = r_err;
  assign dbg_state   = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_gap_ld    <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_gap_ld    <= w_gap_ld_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_gap_ld_nxt    = r_gap_ld;
    w_gap_cnt_nxt   = r_gap_cnt;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_gap_ld_nxt = req_gap;
          if (req_len != '0) begin
            w_state_nxt     = EMIT;
            w_remaining_nxt = req_len;
          end
        end
      end
      EMIT: begin
        if (w_abort) begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
        end else if (w_tok) begin
          if (r_remaining == CNT_W'(1)) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
          end else begin
            w_remaining_nxt = r_remaining - CNT_W'(1);
            if (r_gap_ld != '0) begin
              w_state_nxt   = GAP;
              w_gap_cnt_nxt = r_gap_ld;
            end
          end
        end
      end
      GAP: begin
        // Counting g down to 1 yields exactly g idle cycles between tokens.
        if (w_abort) begin
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
          w_gap_cnt_nxt   = '0;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt   = EMIT;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Credits: tok and ret together cancel; a stray ret saturates at 0 and flags err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_tok, ret})
        2'b10: r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01: begin
          if (r_outstanding == '0) r_err <= 1'b1;
          else                     r_outstanding <= r_outstanding - OUT_W'(1);
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_token_burst_pacer.sv
// Directed bench for token_burst_pacer (MAX_OUT=4); each task checks its own scenario.
// Defining TOKEN_PACER_ABORT_EN also connects and exercises the abort input.
module tb_token_burst_pacer;

  localparam int CNT_W   = 8;
  localparam int GAP_W   = 4;
  localparam int MAX_OUT = 4;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_len;
  logic [GAP_W-1:0] req_gap;
  logic             ret;
  logic             abort;
  logic             tok;
  logic             busy;
  logic [OUT_W-1:0] outstanding;
  logic             err;
  logic [1:0]       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  token_burst_pacer #(.CNT_W(CNT_W), .GAP_W(GAP_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_len(req_len), .req_gap(req_gap), .ret(ret),
`ifdef TOKEN_PACER_ABORT_EN
    .abort(abort),
`endif
    .tok(tok), .busy(busy), .outstanding(outstanding), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; ret = 1'b0; abort = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic send(input int len, input int gap);
    req_valid = 1'b1; req_len = CNT_W'(len); req_gap = GAP_W'(gap);
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    req_len = '0; req_gap = '0;
    rst = 1'b1; req_valid = 1'b0; ret = 1'b0; abort = 1'b0;
    step(); step();
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL reset_tok got %b want 0", tok); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL reset_out got %0d want 0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_burst_gap0();
    do_reset();
    send(3, 0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tok !== 1'b1) begin n_bad++; $display("FAIL gap0_tok[%0d] got %b want 1", i, tok); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL gap0_ready[%0d] got %b want 0", i, req_ready); end
      step();
    end
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL gap0_tok_end got %b want 0", tok); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL gap0_ready_end got %b want 1", req_ready); end
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL gap0_out got %0d want 3", outstanding); end
  endtask

  task automatic test_burst_gap2();
    logic [4:0] exp_tok;
    logic [4:0] exp_busy;
    exp_tok  = 5'b01001;  // bit i = cycle E+1+i
    exp_busy = 5'b01111;
    do_reset();
    send(2, 2);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (tok !== exp_tok[i]) begin n_bad++; $display("FAIL gap2_tok[E+%0d] got %b want %b", i + 1, tok, exp_tok[i]); end
      n_cmp++; if (busy !== exp_busy[i]) begin n_bad++; $display("FAIL gap2_busy[E+%0d] got %b want %b", i + 1, busy, exp_busy[i]); end
      step();
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    send(6, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tok !== 1'b1) begin n_bad++; $display("FAIL stall_tok[%0d] got %b want 1", i, tok); end
      step();
    end
    step();
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL stall_hold got %b want 0", tok); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy got %b want 1", busy); end
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL stall_out got %0d want 4", outstanding); end
    ret = 1'b1; #1;
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL stall_ret_cycle_tok got %b want 0", tok); end
    step();
    ret = 1'b0;
    n_cmp++; if (tok !== 1'b1) begin n_bad++; $display("FAIL unstall_tok got %b want 1", tok); end
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL unstall_out got %0d want 3", outstanding); end
    step();
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL restall_tok got %b want 0", tok); end
    n_cmp++; if (outstanding !== 3'd4) begin n_bad++; $display("FAIL restall_out got %0d want 4", outstanding); end
    // One token left: free a credit, then return another while it is emitted.
    ret = 1'b1;
    step();
    n_cmp++; if (tok !== 1'b1) begin n_bad++; $display("FAIL last_tok got %b want 1", tok); end
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL pre_same_out got %0d want 3", outstanding); end
    step();
    ret = 1'b0;
    n_cmp++; if (outstanding !== 3'd3) begin n_bad++; $display("FAIL same_cycle_out got %0d want 3", outstanding); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_done_busy got %b want 0", busy); end
  endtask

  task automatic test_err_sticky();
    do_reset();
    ret = 1'b1;
    step();
    ret = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err); end
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL err_out got %0d want 0", outstanding); end
    send(1, 0);
    step(); step();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err); end
    n_cmp++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL err_then_tok_out got %0d want 1", outstanding); end
    do_reset();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", err); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    send(10, 0);
    step(); step(); step();
    rst = 1'b1; #1;
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL midrst_tok got %b want 0", tok); end
    step();
    rst = 1'b0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL midrst_out got %0d want 0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err got %b want 0", err); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL midrst_after_tok[%0d] got %b want 0", i, tok); end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send(0, 3);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got %b want 0", busy); end
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL zero_tok got %b want 0", tok); end
    step();
    n_cmp++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL zero_out got %0d want 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tok;
    logic [3:0] exp_ready;
    exp_tok   = 4'b0101;  // bit i = cycle E+1+i, request held valid throughout
    exp_ready = 4'b1010;
    do_reset();
    req_valid = 1'b1; req_len = CNT_W'(1); req_gap = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tok !== exp_tok[i]) begin n_bad++; $display("FAIL b2b_tok[E+%0d] got %b want %b", i + 1, tok, exp_tok[i]); end
      n_cmp++; if (req_ready !== exp_ready[i]) begin n_bad++; $display("FAIL b2b_ready[E+%0d] got %b want %b", i + 1, req_ready, exp_ready[i]); end
      if (i == 2) req_valid = 1'b0;
      step();
    end
  endtask

`ifdef TOKEN_PACER_ABORT_EN
  task automatic test_abort();
    do_reset();
    send(8, 0);
    step(); step();
    abort = 1'b1; #1;
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL abort_tok got %b want 0", tok); end
    step();
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (outstanding !== 3'd2) begin n_bad++; $display("FAIL abort_out got %0d want 2", outstanding); end
    step();
    n_cmp++; if (tok !== 1'b0) begin n_bad++; $display("FAIL abort_after_tok got %b want 0", tok); end
  endtask
`endif

  initial begin
    test_reset();
    test_burst_gap0();
    test_burst_gap2();
    test_credit_stall();
    test_err_sticky();
    test_reset_mid_burst();
    test_zero_len();
    test_back_to_back();
`ifdef TOKEN_PACER_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
